// File: rtl/register_dump_controller_pkg.sv
// Shared definitions for the register dump sequencer: FSM state encoding and
// byte-serialisation sizing helpers.
package register_dump_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        SEND   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A one-byte word still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NB_DATA    = 32;
    localparam int DEF_NB_BYTE    = 8;
    localparam int BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;
    localparam int BYTE_CNT_W     = cnt_width(BYTES_PER_WORD);

endpackage

// File: rtl/register_dump_controller_word_serializer.sv
// Holds one captured register word and hands it out a byte at a time, MSB
// byte first, over a valid/ready handshake.
module word_serializer
    import register_dump_controller_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_BYTE = DEF_NB_BYTE,
    parameter int BPW     = BYTES_PER_WORD,
    parameter int CNT_W   = BYTE_CNT_W
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_active,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last,
    output logic               o_transfer
);

    logic [NB_DATA-1:0] word;
    logic [CNT_W-1:0]   count;
    logic [NB_DATA-1:0] shifted;

    // NOTE: the captured word is an ordinary register, not a memory, so it is
    // reset; that keeps o_tx_data at zero while the block is held in reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word  <= '0;
            count <= '0;
        end else if (i_load) begin
            word  <= i_word;
            count <= '0;
        end else if (o_transfer && !o_last) begin
            count <= count + 1'b1;
        end
    end

    // Shift the selected byte up to the top so the output slice is constant.
    assign shifted    = word << (count * NB_BYTE);
    assign o_tx_data  = shifted[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid = i_active;
    assign o_last     = (count == CNT_W'(BPW - 1));
    assign o_transfer = i_active && i_tx_ready;

endmodule

// File: rtl/register_dump_controller.sv
// Walks every register-bank entry through read port 1 after a debug halt and
// streams each word to the UART tx FIFO, MSB byte first.
module register_dump_controller
    import register_dump_controller_pkg::*;
#(
    parameter int NB_DATA     = DEF_NB_DATA,
    parameter int N_REGISTERS = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_BYTE     = DEF_NB_BYTE
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic [NB_REGISTER-1:0] o_rb_sel,
    output logic                   o_rb_valid,
    input  logic [NB_DATA-1:0]     i_rb_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BPW   = NB_DATA / NB_BYTE;
    localparam int CNT_W = cnt_width(BPW);

    state_t                 state;
    logic [NB_REGISTER-1:0] index;
    logic                   last_byte;
    logic                   transfer;

    // NOTE: all state uses non-blocking assignments so every branch reads the
    // pre-edge values of state and index.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= SELECT;
                        index <= '0;
                    end
                end
                SELECT: state <= SEND;
                SEND: begin
                    if (transfer && last_byte) begin
                        if (index == NB_REGISTER'(N_REGISTERS - 1)) begin
                            state <= DONE;
                        end else begin
                            index <= index + 1'b1;
                            state <= SELECT;
                        end
                    end
                end
                DONE: begin
                    index <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; i_tx_ready never reaches o_tx_valid.
    assign o_rb_sel   = index;
    assign o_rb_valid = (state == SELECT);
    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);

    word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE),
        .BPW     (BPW),
        .CNT_W   (CNT_W)
    ) u_word_serializer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (state == SELECT),
        .i_word     (i_rb_data),
        .i_active   (state == SEND),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_last     (last_byte),
        .o_transfer (transfer)
    );

endmodule
